// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word and RAM status encoding.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

endpackage

// File: rtl/cache_arbiter_if.sv
// Cache-side and RAM-side signals of the cache arbiter, grouped as one bus.
interface cache_arbiter_if;
  import cpu_types_pkg::*;

  logic      iREN;
  word_t     iaddr;
  logic      iwait;
  word_t     iload;

  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  logic      dwait;
  word_t     dload;

  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;

  // Arbiter side.
  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  // Caches plus RAM, i.e. everything around the arbiter.
  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

endinterface

// File: rtl/cache_arbiter.sv
// Single-port RAM arbiter between icache and dcache: dcache priority with an
// anti-starvation override for icache, one grant per word.
module cache_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic            CLK,
  input logic            nRST,
  cache_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle,
    StDgrant,
    StIgrant
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] starve_q, starve_d;
  logic       arb_en_q;
  logic       i_access, d_access, d_req, i_starved;

  assign d_req     = bus.dREN | bus.dWEN;
  assign i_access  = (state_q == StIgrant) && (bus.ramstate == ACCESS);
  assign d_access  = (state_q == StDgrant) && (bus.ramstate == ACCESS);
  assign i_starved = (32'(starve_q) >= STARVE_LIMIT) && bus.iREN;

  // Arbitration is held off for the first edge after reset release.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= StIdle;
      starve_q <= 3'd0;
      arb_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      arb_en_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (arb_en_q) begin
          if (i_starved)     state_d = StIgrant;
          else if (d_req)    state_d = StDgrant;
          else if (bus.iREN) state_d = StIgrant;
        end
      end
      StDgrant: if (d_access || !d_req)    state_d = StIdle;
      StIgrant: if (i_access || !bus.iREN) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Clear wins over increment; saturate at 7.
  always_comb begin
    starve_d = starve_q;
    if (!bus.iREN || i_access) begin
      starve_d = 3'd0;
    end else if (d_access && (starve_q != 3'd7)) begin
      starve_d = starve_q + 3'd1;
    end
  end

  always_comb begin
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    bus.iwait    = 1'b1;
    bus.dwait    = 1'b1;
    unique case (state_q)
      StDgrant: begin
        bus.ramaddr  = bus.daddr;
        bus.ramstore = bus.dstore;
        bus.ramWEN   = bus.dWEN;
        bus.ramREN   = bus.dREN & ~bus.dWEN;
        bus.dwait    = ~d_access;
      end
      StIgrant: begin
        bus.ramaddr = bus.iaddr;
        bus.ramREN  = bus.iREN;
        bus.iwait   = ~i_access;
      end
      default: ;
    endcase
  end

  assign bus.iload = bus.ramload;
  assign bus.dload = bus.ramload;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: per-cycle expected bus values are queued
// as stimulus is applied and popped when the outputs are sampled.
module tb_cache_arbiter;
  import cpu_types_pkg::*;

  typedef struct packed {
    logic  ren;
    logic  wen;
    word_t addr;
    word_t store;
    logic  iw;
    logic  dw;
    word_t load;
  } exp_t;

  logic    clk = 1'b0;
  logic    nrst;
  exp_t    exp_q[$];
  string   tag_q[$];
  int      tests = 0;
  int      fails = 0;

  cache_arbiter_if bus ();

  cache_arbiter #(.STARVE_LIMIT(4)) dut (
    .CLK  (clk),
    .nRST (nrst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(string tag, string fld, word_t got, word_t want);
    tests++;
    assert (got === want)
    else begin
      fails++;
      $error("FAIL %s.%s got %h required %h", tag, fld, got, want);
    end
  endtask

  task automatic push_exp(string tag, logic ren, logic wen, word_t addr, word_t store,
                          logic iw, logic dw);
    exp_t e;
    e.ren = ren; e.wen = wen; e.addr = addr; e.store = store;
    e.iw = iw; e.dw = dw; e.load = bus.ramload;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic check_now();
    exp_t  e;
    string t;
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard: got empty queue, required an entry");
      return;
    end
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    chk(t, "ramREN",   {31'd0, bus.ramREN}, {31'd0, e.ren});
    chk(t, "ramWEN",   {31'd0, bus.ramWEN}, {31'd0, e.wen});
    chk(t, "ramaddr",  bus.ramaddr,         e.addr);
    chk(t, "ramstore", bus.ramstore,        e.store);
    chk(t, "iwait",    {31'd0, bus.iwait},  {31'd0, e.iw});
    chk(t, "dwait",    {31'd0, bus.dwait},  {31'd0, e.dw});
    chk(t, "iload",    bus.iload,           e.load);
    chk(t, "dload",    bus.dload,           e.load);
  endtask

  // One clock cycle: expectation queued, sampled mid-cycle, then next edge.
  task automatic cyc(string tag, logic ren, logic wen, word_t addr, word_t store,
                     logic iw, logic dw);
    push_exp(tag, ren, wen, addr, store, iw, dw);
    @(negedge clk);
    check_now();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(string tag);
    cyc(tag, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
  endtask

  initial begin
    nrst = 1'b1;
    bus.iREN = 1'b1; bus.iaddr = 32'h40;
    bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.daddr = '0; bus.dstore = '0;
    bus.ramload = 32'h1111_2222; bus.ramstate = FREE;
    #1 nrst = 1'b0;

    // Reset holds IDLE outputs even with a request pending.
    idle("rst0");
    idle("rst1");
    nrst = 1'b1;

    // First edge after release only enables arbitration.
    idle("post0");
    idle("post1");

    // Icache single word.
    cyc("ig_free", 1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 1'b1);
    bus.ramstate = BUSY;
    cyc("ig_busy", 1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 1'b1);
    bus.ramstate = ACCESS; bus.ramload = 32'hDEAD_BEEF;
    cyc("ig_acc", 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b1);
    bus.iREN = 1'b0; bus.ramstate = FREE;
    idle("ig_turn");

    // Simultaneous requests: dcache first, then icache.
    bus.iREN = 1'b1; bus.iaddr = 32'h44;
    bus.dWEN = 1'b1; bus.daddr = 32'h80; bus.dstore = 32'h1234;
    idle("both_arb");
    cyc("dw_free", 1'b0, 1'b1, 32'h80, 32'h1234, 1'b1, 1'b1);
    bus.ramstate = ACCESS;
    cyc("dw_acc", 1'b0, 1'b1, 32'h80, 32'h1234, 1'b1, 1'b0);
    bus.dWEN = 1'b0; bus.dstore = '0; bus.ramstate = FREE;
    idle("dw_turn");
    cyc("ig2_free", 1'b1, 1'b0, 32'h44, 32'h0, 1'b1, 1'b1);
    bus.ramstate = ACCESS; bus.ramload = 32'hCAFE_F00D;
    cyc("ig2_acc", 1'b1, 1'b0, 32'h44, 32'h0, 1'b0, 1'b1);
    bus.iREN = 1'b0; bus.ramstate = FREE;
    idle("ig2_turn");

    // Starvation: four dcache words, then icache, then the fifth dcache word.
    bus.iREN = 1'b1; bus.iaddr = 32'h48; bus.dREN = 1'b1; bus.ramstate = ACCESS;
    for (int w = 0; w < 4; w++) begin
      bus.daddr = 32'h100 + 32'(4 * w);
      idle("st_idle");
      cyc("st_dg", 1'b1, 1'b0, bus.daddr, 32'h0, 1'b1, 1'b0);
    end
    idle("st_idle4");
    cyc("st_ig", 1'b1, 1'b0, 32'h48, 32'h0, 1'b0, 1'b1);
    bus.daddr = 32'h110;
    idle("st_idle5");
    cyc("st_dg5", 1'b1, 1'b0, 32'h110, 32'h0, 1'b1, 1'b0);
    bus.iREN = 1'b0; bus.dREN = 1'b0; bus.ramstate = FREE;
    idle("st_end");

    // Read+write with ERROR: write wins, grant held until ACCESS.
    bus.dREN = 1'b1; bus.dWEN = 1'b1; bus.daddr = 32'h200; bus.dstore = 32'h55AA;
    bus.ramstate = ERROR;
    idle("err_arb");
    for (int k = 0; k < 3; k++) cyc("err_hold", 1'b0, 1'b1, 32'h200, 32'h55AA, 1'b1, 1'b1);
    bus.ramstate = ACCESS;
    cyc("err_acc", 1'b0, 1'b1, 32'h200, 32'h55AA, 1'b1, 1'b0);
    bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.dstore = '0; bus.ramstate = FREE;
    idle("err_end");

    // Dcache drops its request mid-grant; pending icache follows.
    bus.dREN = 1'b1; bus.daddr = 32'h300; bus.iREN = 1'b1; bus.iaddr = 32'h4C;
    bus.ramstate = BUSY;
    idle("drop_arb");
    cyc("drop_dg", 1'b1, 1'b0, 32'h300, 32'h0, 1'b1, 1'b1);
    bus.dREN = 1'b0;
    cyc("drop_cyc", 1'b0, 1'b0, 32'h300, 32'h0, 1'b1, 1'b1);
    idle("drop_idle");
    cyc("drop_ig", 1'b1, 1'b0, 32'h4C, 32'h0, 1'b1, 1'b1);
    bus.ramstate = ACCESS; bus.ramload = 32'h600D_F00D;
    cyc("drop_igacc", 1'b1, 1'b0, 32'h4C, 32'h0, 1'b0, 1'b1);
    bus.iREN = 1'b0; bus.ramstate = FREE;
    idle("drop_end");

    // Build starvation count to 3, then reset mid-grant.
    bus.iREN = 1'b1; bus.iaddr = 32'h50; bus.dREN = 1'b1; bus.daddr = 32'h400;
    bus.dstore = 32'h77; bus.ramstate = ACCESS;
    for (int w = 0; w < 3; w++) begin
      idle("pre_idle");
      cyc("pre_dg", 1'b1, 1'b0, 32'h400, 32'h77, 1'b1, 1'b0);
    end
    bus.dWEN = 1'b1; bus.ramstate = BUSY;
    idle("pre_idle3");
    cyc("pre_busy", 1'b0, 1'b1, 32'h400, 32'h77, 1'b1, 1'b1);
    #2;
    push_exp("mid_grant", 1'b0, 1'b1, 32'h400, 32'h77, 1'b1, 1'b1);
    check_now();
    nrst = 1'b0;
    push_exp("async_rst", 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    #1;
    check_now();
    @(posedge clk);
    #1;
    nrst = 1'b1; bus.ramstate = ACCESS;
    idle("rel0");
    idle("rel1");
    cyc("rel_dg1", 1'b0, 1'b1, 32'h400, 32'h77, 1'b1, 1'b0);
    // Count was cleared, so dcache still wins here.
    idle("rel_idle");
    cyc("rel_dg2", 1'b0, 1'b1, 32'h400, 32'h77, 1'b1, 1'b0);
    bus.iREN = 1'b0; bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.ramstate = FREE;
    idle("final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
